// File: rtl/coin_credit_ctrl_pkg.sv
// Shared definitions for the coin/credit front end and the dispenser FSM:
// state encodings, coin values, credit limits and button indices.
package coin_credit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_VEND    = 3'd2,
        ST_REFUND  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam int         CREDIT_W   = 3;
    localparam logic [3:0] COIN1_VAL  = 4'd1;
    localparam logic [3:0] COIN2_VAL  = 4'd2;
    localparam logic [3:0] CREDIT_MAX = 4'd7;

    localparam int BTN_COIN1  = 0;
    localparam int BTN_COIN2  = 1;
    localparam int BTN_SELA   = 2;
    localparam int BTN_SELB   = 3;
    localparam int BTN_SELC   = 4;
    localparam int BTN_CANCEL = 5;
    localparam int BTN_NUM    = 6;

    // Value of the coin pulses seen in one cycle; both together count as 3.
    function automatic logic [3:0] coin_value(input logic c1, input logic c2);
        return (c1 ? COIN1_VAL : 4'd0) + (c2 ? COIN2_VAL : 4'd0);
    endfunction

endpackage

// File: rtl/coin_credit_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge
// detector; a held button yields a single one-cycle pulse.
module coin_credit_ctrl_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin/credit front end: conditions buttons, accumulates credit, starts a vend
// when credit covers the selected price, then refunds leftover credit.
module coin_credit_ctrl
    import coin_credit_ctrl_pkg::*;
#(
    parameter logic [2:0] PRICE_A = 3'd3,
    parameter logic [2:0] PRICE_B = 3'd5,
    parameter logic [2:0] PRICE_C = 3'd7,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                coin1_i,
    input  logic                coin2_i,
    input  logic                sela_i,
    input  logic                selb_i,
    input  logic                selc_i,
    input  logic                cancel_i,
    input  logic                done_i,
    output logic                e_o,
    output logic                a_o,
    output logic                b_o,
    output logic                c_o,
    output logic [CREDIT_W-1:0] cin_o,
    output logic                rej_o,
    output logic                ret_o,
    output logic                fault_o
);

    logic [BTN_NUM-1:0] raw_vec;
    logic [BTN_NUM-1:0] pulse_vec;

    assign raw_vec[BTN_COIN1]  = coin1_i;
    assign raw_vec[BTN_COIN2]  = coin2_i;
    assign raw_vec[BTN_SELA]   = sela_i;
    assign raw_vec[BTN_SELB]   = selb_i;
    assign raw_vec[BTN_SELC]   = selc_i;
    assign raw_vec[BTN_CANCEL] = cancel_i;

    genvar gi;
    generate
        for (gi = 0; gi < BTN_NUM; gi++) begin : g_btn
            coin_credit_ctrl_sync_edge u_sync (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .raw_i  (raw_vec[gi]),
                .pulse_o(pulse_vec[gi])
            );
        end
    endgenerate

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [2:0]          sel_q, sel_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                e_q, e_d;
    logic                rej_q, rej_d;
    logic                ret_q, ret_d;
    logic                fault_q, fault_d;

    logic [3:0]          coin_val;
    logic [3:0]          coin_sum;
    logic                coin_any;
    logic                coin_fits;
    logic [CREDIT_W-1:0] credit_after;
    logic                sel_any;
    logic [2:0]          sel_hot;
    logic [2:0]          sel_price;

    assign coin_val     = coin_value(pulse_vec[BTN_COIN1], pulse_vec[BTN_COIN2]);
    assign coin_any     = pulse_vec[BTN_COIN1] | pulse_vec[BTN_COIN2];
    assign coin_sum     = {1'b0, credit_q} + coin_val;
    assign coin_fits    = (coin_sum <= CREDIT_MAX);
    assign credit_after = (coin_any && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit_q;
    assign sel_any      = pulse_vec[BTN_SELA] | pulse_vec[BTN_SELB] | pulse_vec[BTN_SELC];

    // A beats B beats C when several selections arrive together.
    always_comb begin
        sel_hot   = 3'b000;
        sel_price = PRICE_C;
        if (pulse_vec[BTN_SELA]) begin
            sel_hot   = 3'b001;
            sel_price = PRICE_A;
        end else if (pulse_vec[BTN_SELB]) begin
            sel_hot   = 3'b010;
            sel_price = PRICE_B;
        end else if (pulse_vec[BTN_SELC]) begin
            sel_hot   = 3'b100;
            sel_price = PRICE_C;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        rej_d    = 1'b0;
        ret_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                rej_d = coin_any && !coin_fits;
                // The price is judged on credit held before this cycle's coin.
                if (state_q == ST_COLLECT && sel_any && credit_q >= sel_price) begin
                    sel_d    = sel_hot;
                    credit_d = credit_after - sel_price;
                    tmo_d    = 8'd0;
                    state_d  = ST_VEND;
                end else if (state_q == ST_COLLECT && pulse_vec[BTN_CANCEL]) begin
                    credit_d = credit_after;
                    state_d  = ST_REFUND;
                end else begin
                    credit_d = credit_after;
                    state_d  = (credit_after != '0) ? ST_COLLECT : ST_IDLE;
                end
            end
            ST_VEND: begin
                rej_d = coin_any;
                if (done_i) begin
                    sel_d   = 3'b000;
                    state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
                end else if (tmo_q == TIMEOUT - 8'd1) begin
                    sel_d   = 3'b000;
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_REFUND: begin
                rej_d = coin_any;
                if (credit_q != '0) begin
                    credit_d = credit_q - 3'd1;
                    ret_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                rej_d = coin_any;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        e_d     = (state_d == ST_VEND);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            sel_q    <= 3'b000;
            tmo_q    <= 8'd0;
            e_q      <= 1'b0;
            rej_q    <= 1'b0;
            ret_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            tmo_q    <= tmo_d;
            e_q      <= e_d;
            rej_q    <= rej_d;
            ret_q    <= ret_d;
            fault_q  <= fault_d;
        end
    end

    assign e_o     = e_q;
    assign a_o     = sel_q[0];
    assign b_o     = sel_q[1];
    assign c_o     = sel_q[2];
    assign cin_o   = credit_q;
    assign rej_o   = rej_q;
    assign ret_o   = ret_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed bench for coin_credit_ctrl; outputs are compared as one packed
// vector {E,A,B,C}_{CIN}_{REJ,RET,FAULT}.
module tb_coin_credit_ctrl;

    localparam logic [7:0] TMO   = 8'd255;
    localparam int         TMO_I = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin1, coin2, sela, selb, selc, cancel, done;
    logic       e, a, b, c, rej, ret, fault;
    logic [2:0] cin;
    logic [9:0] outs;
    logic [9:0] exp_v;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    coin_credit_ctrl #(
        .PRICE_A(3'd3),
        .PRICE_B(3'd5),
        .PRICE_C(3'd7),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .coin1_i (coin1),
        .coin2_i (coin2),
        .sela_i  (sela),
        .selb_i  (selb),
        .selc_i  (selc),
        .cancel_i(cancel),
        .done_i  (done),
        .e_o     (e),
        .a_o     (a),
        .b_o     (b),
        .c_o     (c),
        .cin_o   (cin),
        .rej_o   (rej),
        .ret_o   (ret),
        .fault_o (fault)
    );

    assign outs = {e, a, b, c, cin, rej, ret, fault};

    // Button mask order: {cancel, selc, selb, sela, coin2, coin1}.
    // Returns 1 ns after the edge where the conditioned press takes effect.
    task automatic press(input logic [5:0] m);
        @(negedge clk);
        {cancel, selc, selb, sela, coin2, coin1} = m;
        repeat (3) @(posedge clk);
        #1;
        $display("press %b -> outs %b", m, outs);
    endtask

    task automatic release_btns();
        {cancel, selc, selb, sela, coin2, coin1} = 6'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        $display("done pulse -> outs %b", outs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {cancel, selc, selb, sela, coin2, coin1} = 6'b0;
        done = 1'b0;
        #2;
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, exp_v); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL reset_idle got=%b exp=%b", outs, exp_v); end
    endtask

    task automatic test_vend_exact();
        @(negedge clk);
        coin2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_latency got=%b exp=%b", outs, exp_v); end
        tick();
        exp_v = 10'b0000_010_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_coin2 got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b000001);
        exp_v = 10'b0000_011_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_coin1 got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b000100);
        exp_v = 10'b1100_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_sela got=%b exp=%b", outs, exp_v); end
        release_btns();
        exp_v = 10'b1100_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_vend_hold got=%b exp=%b", outs, exp_v); end
        pulse_done();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_done got=%b exp=%b", outs, exp_v); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t1_no_ret[%0d] got=%b exp=%b", i, outs, exp_v); end
        end
    endtask

    task automatic test_vend_change();
        press(6'b000010); release_btns();
        exp_v = 10'b0000_010_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_c2 got=%b exp=%b", outs, exp_v); end
        press(6'b000010); release_btns();
        exp_v = 10'b0000_100_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_c4 got=%b exp=%b", outs, exp_v); end
        press(6'b000010); release_btns();
        exp_v = 10'b0000_110_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_c6 got=%b exp=%b", outs, exp_v); end
        press(6'b001000);
        exp_v = 10'b1010_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_selb got=%b exp=%b", outs, exp_v); end
        release_btns();
        pulse_done();
        exp_v = 10'b0000_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_done got=%b exp=%b", outs, exp_v); end
        tick();
        exp_v = 10'b0000_000_010; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_ret got=%b exp=%b", outs, exp_v); end
        tick();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t2_idle got=%b exp=%b", outs, exp_v); end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 3; i++) begin
            press(6'b000010); release_btns();
        end
        exp_v = 10'b0000_110_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_c6 got=%b exp=%b", outs, exp_v); end
        press(6'b000010);
        exp_v = 10'b0000_110_100; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_rej2 got=%b exp=%b", outs, exp_v); end
        release_btns();
        exp_v = 10'b0000_110_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_rej_clear got=%b exp=%b", outs, exp_v); end
        press(6'b000001);
        exp_v = 10'b0000_111_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_c7 got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b000001);
        exp_v = 10'b0000_111_100; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_rej1 got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b010000);
        exp_v = 10'b1001_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_selc got=%b exp=%b", outs, exp_v); end
        release_btns();
        pulse_done();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t3_done got=%b exp=%b", outs, exp_v); end
    endtask

    task automatic test_cancel();
        press(6'b000010); release_btns();
        press(6'b000010); release_btns();
        press(6'b001000);
        exp_v = 10'b0000_100_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t4_selb_low got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b100000);
        exp_v = 10'b0000_100_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t4_cancel got=%b exp=%b", outs, exp_v); end
        for (int k = 3; k >= 0; k--) begin
            tick();
            exp_v = {4'b0000, 3'(k), 3'b010};
            checks++; if (outs !== exp_v) begin errors++; $display("FAIL t4_refund[%0d] got=%b exp=%b", k, outs, exp_v); end
        end
        tick();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t4_idle got=%b exp=%b", outs, exp_v); end
        release_btns();
    endtask

    task automatic test_dual_coin();
        press(6'b000011); release_btns();
        exp_v = 10'b0000_011_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_c3 got=%b exp=%b", outs, exp_v); end
        press(6'b000011); release_btns();
        exp_v = 10'b0000_110_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_c6 got=%b exp=%b", outs, exp_v); end
        press(6'b000011);
        exp_v = 10'b0000_110_100; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_rej got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b001100);
        exp_v = 10'b1100_011_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_prio got=%b exp=%b", outs, exp_v); end
        release_btns();
        pulse_done();
        exp_v = 10'b0000_011_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_done got=%b exp=%b", outs, exp_v); end
        for (int k = 2; k >= 0; k--) begin
            tick();
            exp_v = {4'b0000, 3'(k), 3'b010};
            checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_refund[%0d] got=%b exp=%b", k, outs, exp_v); end
        end
        tick();
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL td_idle got=%b exp=%b", outs, exp_v); end
    endtask

    task automatic test_timeout();
        press(6'b000010); release_btns();
        press(6'b000010); release_btns();
        press(6'b000100);
        sela = 1'b0;
        exp_v = 10'b1100_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_vend got=%b exp=%b", outs, exp_v); end
        repeat (TMO_I - 1) @(posedge clk);
        #1;
        exp_v = 10'b1100_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_pre_fault got=%b exp=%b", outs, exp_v); end
        tick();
        exp_v = 10'b0000_001_001; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_fault got=%b exp=%b", outs, exp_v); end
        press(6'b000001);
        exp_v = 10'b0000_001_101; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_coin_rej got=%b exp=%b", outs, exp_v); end
        release_btns();
        press(6'b001000);
        exp_v = 10'b0000_001_001; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_sel_ign got=%b exp=%b", outs, exp_v); end
        release_btns();
        pulse_done();
        exp_v = 10'b0000_001_001; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_stuck got=%b exp=%b", outs, exp_v); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t5_reset got=%b exp=%b", outs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        press(6'b000010); release_btns();
        press(6'b000010); release_btns();
        press(6'b000100);
        exp_v = 10'b1100_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t6_vend got=%b exp=%b", outs, exp_v); end
        release_btns();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_v = 10'b0000_000_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t6_async got=%b exp=%b", outs, exp_v); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        coin1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        $display("held coin1 -> outs %b", outs);
        exp_v = 10'b0000_001_000; checks++; if (outs !== exp_v) begin errors++; $display("FAIL t6_held got=%b exp=%b", outs, exp_v); end
        release_btns();
    endtask

    initial begin
        test_reset();
        test_vend_exact();
        test_vend_change();
        test_reject();
        test_cancel();
        test_dual_coin();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_credit_ctrl.md
Name: coin_credit_ctrl

Overview:
Upstream stage of the dispenser FSM. Conditions the raw coin, selection and cancel buttons. Accumulates credit and checks it against the price of the selected product. When credit covers the price, it drives the dispenser's E, A, B, C and CIN inputs. It waits for the dispenser's DONE, then refunds any remaining credit one unit per cycle.

Parameters:
PRICE_A, 3, price of product A in credit units (1..7)
PRICE_B, 5, price of product B in credit units (1..7)
PRICE_C, 7, price of product C in credit units (1..7)
TIMEOUT, 255, max cycles in VEND without DONE before FAULT (8-bit counter)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset (RESET=0 clears all state)
COIN1  in  1  raw button, 1-unit coin inserted (async, level)
COIN2  in  1  raw button, 2-unit coin inserted (async, level)
SELA, SELB, SELC  in  1 each  raw product-select buttons
CANCEL  in  1  raw button, request refund
DONE  in  1  synchronous 1-cycle pulse from dispenser: dispense finished
E  out  1  vend enable to dispenser
A, B, C  out  1 each  latched one-hot selection to dispenser
CIN  out  3  current credit (0..7) to dispenser
REJ  out  1  1-cycle pulse: coin rejected, return it
RET  out  1  refund strobe: one unit returned per cycle high
FAULT  out  1  high in FAULT state

Behaviour:
- Reset (RESET=0, async): state=IDLE; credit=0; E=A=B=C=REJ=RET=FAULT=0; CIN=0; sync flops=0; timeout counter=0.
- Conditioning: each raw button uses a 2-FF synchronizer, then rising-edge detect (1-cycle pulse). A raw rise sampled at edge n gives a pulse after edge n+1. The register update lands at edge n+2. A held button gives one pulse only. DONE is not synchronized.
- States: IDLE (credit=0), COLLECT (credit>0), VEND, REFUND, FAULT. Encoding lives in the shared header.
- Coin handling in IDLE/COLLECT:
  - If credit+value ≤ 7, add the value and go to COLLECT.
  - Otherwise credit is unchanged and REJ=1 for 1 cycle.
  - COIN1 and COIN2 pulses in the same cycle: accept the sum 3 if it fits, else reject both with a single REJ pulse.
- Coin pulses in VEND/REFUND/FAULT: rejected (REJ pulse), credit unchanged.
- Selection in COLLECT:
  - Priority A>B>C when several pulse together.
  - If credit ≥ price: latch one-hot A/B/C, credit -= price, go to VEND next edge.
  - If credit < price: ignored, stay in COLLECT.
  - Selection in IDLE/VEND/REFUND: ignored.
- CANCEL:
  - In COLLECT: go to REFUND.
  - In IDLE/VEND/REFUND: ignored.
  - Same cycle as a valid selection: the selection wins.
- VEND:
  - E=1 and A/B/C held stable; CIN shows remaining credit.
  - Timeout counter clears on entry and increments each cycle.
  - DONE: clear E/A/B/C; go to REFUND if credit>0, else IDLE.
  - Counter reaches TIMEOUT with no DONE: go to FAULT. DONE in the same cycle as the timeout wins.
- REFUND: while credit>0, RET=1 and credit decrements by 1 every cycle. Credit k gives exactly k consecutive RET cycles, then IDLE with RET=0.
- FAULT: E=0, A=B=C=0, FAULT=1, credit frozen, all inputs ignored. Exits only via reset.
- DONE outside VEND: ignored.
- Reset mid-operation: immediate clear of all state; credit is lost, with no refund.
- All outputs registered. CIN equals the credit register.

Decomposition:
- Shared header disp_defs.vh: state encodings, coin values (1, 2), CREDIT_MAX=7. The dispenser FSM includes it too.
- One sub-module, sync_edge: 2-FF synchronizer plus rising-edge detector with active-low async reset. Instantiated 6 times (COIN1, COIN2, SELA, SELB, SELC, CANCEL).

Test Plan:
1. Reset, COIN2, COIN1 (separate presses) -> CIN 0→2→3. SELA -> E=1, A=1, CIN=0; DONE -> E=0, state IDLE, RET never high.
2. COIN2 ×3 -> CIN=6. SELB -> E=1, B=1, CIN=1; DONE -> RET high exactly 1 cycle, CIN=0, IDLE.
3. Credit 6, COIN2 -> REJ 1 cycle, CIN stays 6. COIN1 -> CIN=7. COIN1 -> REJ, CIN=7. SELC -> VEND with C=1, CIN=0.
4. Credit 4, SELB -> no E, stays COLLECT. CANCEL -> RET high 4 consecutive cycles, CIN 3,2,1,0, then IDLE.
5. Enter VEND, withhold DONE -> FAULT=1 at cycle TIMEOUT, E=0. Further coins give REJ; selections ignored; RESET=0 -> all outputs 0.
6. Mid-VEND pulse RESET low asynchronously between clock edges -> E, A/B/C, CIN drop to 0 immediately. Held COIN1 button -> exactly one credit increment.
